// File: rtl/ascon_output_serializer_if.sv
// Output word stream of the Ascon output serializer.
// Carries the data word, valid/ready handshake, last marker and tag flag.
interface ascon_output_serializer_if #(
  parameter int WORD_W = 64
);
  logic [WORD_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;
  logic              m_is_tag;

  modport master (
    output m_data,
    output m_valid,
    output m_last,
    output m_is_tag,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    input  m_last,
    input  m_is_tag,
    output m_ready
  );
endinterface

// File: rtl/ascon_output_serializer.sv
// Captures the Ascon core data/tag result in one cycle and streams it
// out as WORD_W words with last/tag markers; counts completed frames.
module ascon_output_serializer #(
  parameter int DATA_W = 256,
  parameter int TAG_W  = 128,
  parameter int WORD_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [1:0]        i_mode,
  input  logic [DATA_W-1:0] i_c_in,
  input  logic [TAG_W-1:0]  i_t_in,
  output logic              o_load_ready,
  output logic              o_busy,
  output logic              o_overrun,
  output logic [15:0]       o_frame_cnt,
  ascon_output_serializer_if.master m_bus
);
  localparam int DW = DATA_W / WORD_W;
  localparam int TW = TAG_W / WORD_W;
  localparam int NW = DW + TW;
  localparam int IW = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic {
    S_IDLE,
    S_SEND
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [DATA_W-1:0] r_c;
  logic [TAG_W-1:0]  r_t;
  logic              r_enc;
  logic [IW-1:0]     r_idx;
  logic [IW-1:0]     w_idx_nx;
  logic [15:0]       r_frame_cnt;
  logic              r_overrun;

  logic              w_send;
  logic              w_cap;
  logic              w_done;
  logic              w_last;
  logic [IW-1:0]     w_last_idx;

  logic [NW-1:0][WORD_W-1:0] w_words;

  // Tag words sit above the data words, so word k is a flat slice.
  assign w_words    = {r_t, r_c};
  assign w_last_idx = r_enc ? IW'(NW - 1) : IW'(DW - 1);
  assign w_last     = (r_idx == w_last_idx);
  assign w_send     = (r_state == S_SEND);

  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_cap      = 1'b0;
    w_done     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_load) begin
          w_state_nx = S_SEND;
          w_idx_nx   = '0;
          w_cap      = 1'b1;
        end
      end
      S_SEND: begin
        if (m_bus.m_ready) begin
          if (w_last) begin
            w_state_nx = S_IDLE;
            w_idx_nx   = '0;
            w_done     = 1'b1;
          end else begin
            w_idx_nx = r_idx + IW'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_c         <= '0;
      r_t         <= '0;
      r_enc       <= 1'b0;
      r_frame_cnt <= '0;
      r_overrun   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_idx   <= w_idx_nx;
      if (w_cap) begin
        r_c   <= i_c_in;
        r_t   <= i_t_in;
        r_enc <= (i_mode == 2'b00);
      end
      if (w_done) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
      // Any load outside IDLE is dropped, including one on the final word.
      if (i_load && w_send) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign m_bus.m_valid  = w_send;
  assign m_bus.m_data   = w_send ? w_words[r_idx] : '0;
  assign m_bus.m_last   = w_send & w_last;
  assign m_bus.m_is_tag = w_send & (r_idx >= IW'(DW));

  assign o_load_ready = ~w_send;
  assign o_busy       = w_send;
  assign o_overrun    = r_overrun;
  assign o_frame_cnt  = r_frame_cnt;
endmodule

// File: tb/tb_ascon_output_serializer.sv
// Self-checking bench for ascon_output_serializer.
// Expected words come from a per-frame queue built from the captured inputs.
module tb_ascon_output_serializer;
  logic         clk = 1'b0;
  logic         rst;
  logic         load;
  logic [1:0]   mode;
  logic [255:0] c_in;
  logic [127:0] t_in;
  logic         load_ready;
  logic         busy;
  logic         overrun;
  logic [15:0]  frame_cnt;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_cnt;
  bit          exp_ovr;

  localparam logic [255:0] KC = {64'h0102030405060737, 64'h0102030405060720,
                                 64'h0102030405060735, 64'h0102030405060720};
  localparam logic [127:0] KT = 128'h57368fee085688e93909d6f8d5cb32af;

  ascon_output_serializer_if #(.WORD_W(64)) bus ();

  ascon_output_serializer dut (
    .clk          (clk),
    .rst          (rst),
    .i_load       (load),
    .i_mode       (mode),
    .i_c_in       (c_in),
    .i_t_in       (t_in),
    .o_load_ready (load_ready),
    .o_busy       (busy),
    .o_overrun    (overrun),
    .o_frame_cnt  (frame_cnt),
    .m_bus        (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [127:0] rnd128();
    logic [127:0] v;
    for (int i = 0; i < 4; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Starts at a negedge with the DUT idle; ends at the negedge after
  // the final handshake so the next call loads at minimum spacing.
  task automatic stream_frame(input logic [255:0] c, input logic [127:0] t,
                              input logic [1:0] m, input int rmode,
                              input int inj_k, input bit inj_fin);
    logic [63:0] q[$];
    bit          tg[$];
    bit          pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int          n, hs, cyc;
    bit          rdy, injd, v;
    n = (m == 2'b00) ? 6 : 4;
    for (int k = 0; k < n; k++) begin
      if (k < 4) q.push_back(c[k*64 +: 64]);
      else       q.push_back(t[(k-4)*64 +: 64]);
      tg.push_back(k >= 4);
    end
    load = 1'b1; mode = m; c_in = c; t_in = t;
    @(negedge clk);
    load = 1'b0; c_in = rnd256(); t_in = rnd128(); mode = 2'($urandom);
    hs = 0; cyc = 0; injd = 1'b0;
    while (hs < n && cyc < 200) begin
      v = bus.m_valid;
      n_checks++;
      if (bus.m_valid !== 1'b1) begin
        n_errors++;
        $display("FAIL m_valid word %0d: got %b exp 1", hs, bus.m_valid);
      end
      n_checks++;
      if (busy !== 1'b1 || load_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL busy/load_ready word %0d: got %b/%b exp 1/0", hs, busy, load_ready);
      end
      n_checks++;
      if (bus.m_data !== q[hs]) begin
        n_errors++;
        $display("FAIL m_data word %0d: got %h exp %h", hs, bus.m_data, q[hs]);
      end
      n_checks++;
      if (bus.m_last !== (hs == n - 1)) begin
        n_errors++;
        $display("FAIL m_last word %0d: got %b exp %b", hs, bus.m_last, hs == n - 1);
      end
      n_checks++;
      if (bus.m_is_tag !== tg[hs]) begin
        n_errors++;
        $display("FAIL m_is_tag word %0d: got %b exp %b", hs, bus.m_is_tag, tg[hs]);
      end
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = pat[cyc % 6];
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      load = 1'b0;
      if (inj_k == hs && !injd) begin
        load = 1'b1; injd = 1'b1; exp_ovr = 1'b1;
      end
      if (inj_fin && hs == n - 1) begin
        rdy = 1'b1; load = 1'b1; exp_ovr = 1'b1;
      end
      bus.m_ready = rdy;
      @(negedge clk);
      load = 1'b0;
      if (rdy && v) hs++;
      cyc++;
    end
    bus.m_ready = 1'($urandom_range(0, 1));
    n_checks++;
    if (cyc >= 200) begin
      n_errors++;
      $display("FAIL frame timeout: got %0d handshakes exp %0d", hs, n);
    end
    exp_cnt = exp_cnt + 16'd1;
    n_checks++;
    if (bus.m_valid !== 1'b0 || load_ready !== 1'b1 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL end-of-frame idle: got valid=%b ready=%b busy=%b exp 0/1/0",
               bus.m_valid, load_ready, busy);
    end
    n_checks++;
    if (bus.m_last !== 1'b0 || bus.m_is_tag !== 1'b0) begin
      n_errors++;
      $display("FAIL idle flags: got last=%b tag=%b exp 0/0", bus.m_last, bus.m_is_tag);
    end
    n_checks++;
    if (frame_cnt !== exp_cnt) begin
      n_errors++;
      $display("FAIL frame_cnt: got %h exp %h", frame_cnt, exp_cnt);
    end
    n_checks++;
    if (overrun !== exp_ovr) begin
      n_errors++;
      $display("FAIL overrun: got %b exp %b", overrun, exp_ovr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b1; mode = 2'b00; c_in = rnd256(); t_in = rnd128();
    bus.m_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; load = 1'b0;
    exp_cnt = 16'd0; exp_ovr = 1'b0;
    n_checks++;
    if (load_ready !== 1'b1 || busy !== 1'b0 || bus.m_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset ctrl: got ready=%b busy=%b valid=%b exp 1/0/0",
               load_ready, busy, bus.m_valid);
    end
    n_checks++;
    if (bus.m_last !== 1'b0 || bus.m_is_tag !== 1'b0 || bus.m_data !== 64'd0) begin
      n_errors++;
      $display("FAIL reset data: got last=%b tag=%b data=%h exp 0/0/0",
               bus.m_last, bus.m_is_tag, bus.m_data);
    end
    n_checks++;
    if (overrun !== 1'b0 || frame_cnt !== 16'd0) begin
      n_errors++;
      $display("FAIL reset status: got ovr=%b cnt=%h exp 0/0", overrun, frame_cnt);
    end
  endtask

  task automatic test_mid_reset();
    load = 1'b1; mode = 2'b00; c_in = rnd256(); t_in = rnd128();
    bus.m_ready = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    rst = 1'b1; load = 1'b1;
    @(negedge clk);
    rst = 1'b0; load = 1'b0;
    n_checks++;
    if (bus.m_valid !== 1'b0 || load_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL mid-frame reset: got valid=%b ready=%b exp 0/1", bus.m_valid, load_ready);
    end
    n_checks++;
    if (frame_cnt !== exp_cnt || overrun !== 1'b0) begin
      n_errors++;
      $display("FAIL mid-frame reset status: got cnt=%h ovr=%b exp %h/0",
               frame_cnt, overrun, exp_cnt);
    end
    stream_frame(rnd256(), rnd128(), 2'b00, 0, -1, 1'b0);
  endtask

  task automatic test_encrypt();
    stream_frame(KC, KT, 2'b00, 0, -1, 1'b0);
  endtask

  task automatic test_dec_hash();
    stream_frame(KC, KT, 2'b01, 0, -1, 1'b0);
    stream_frame(KC, KT, 2'b10, 0, -1, 1'b0);
    stream_frame(rnd256(), rnd128(), 2'b11, 0, -1, 1'b0);
  endtask

  task automatic test_backpressure();
    stream_frame(KC, KT, 2'b00, 1, -1, 1'b0);
    stream_frame(rnd256(), rnd128(), 2'b10, 1, -1, 1'b0);
  endtask

  task automatic test_overrun();
    stream_frame(rnd256(), rnd128(), 2'b00, 2, 2, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 16'd0; exp_ovr = 1'b0;
    n_checks++;
    if (overrun !== 1'b0 || frame_cnt !== 16'd0) begin
      n_errors++;
      $display("FAIL rst clears overrun: got ovr=%b cnt=%h exp 0/0", overrun, frame_cnt);
    end
    stream_frame(rnd256(), rnd128(), 2'b00, 2, -1, 1'b1);
    stream_frame(rnd256(), rnd128(), 2'b01, 2, 1, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 20; i++) begin
      stream_frame(rnd256(), rnd128(), 2'($urandom), $urandom_range(0, 2), -1, 1'b0);
    end
  endtask

  task automatic test_wrap();
    dut.r_frame_cnt = 16'hFFFF;
    exp_cnt = 16'hFFFF;
    @(negedge clk);
    n_checks++;
    if (frame_cnt !== 16'hFFFF) begin
      n_errors++;
      $display("FAIL preload frame_cnt: got %h exp ffff", frame_cnt);
    end
    stream_frame(rnd256(), rnd128(), 2'b10, 0, -1, 1'b0);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; mode = 2'b00; c_in = '0; t_in = '0;
    bus.m_ready = 1'b0;
    exp_cnt = 16'd0; exp_ovr = 1'b0;
    @(negedge clk);
    test_reset();
    test_mid_reset();
    test_encrypt();
    test_dec_hash();
    test_backpressure();
    test_back_to_back();
    test_overrun();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/ascon_output_serializer.md
# ascon_output_serializer

Downstream stage of the Ascon encryption core. Captures the core's 256-bit data result (ciphertext, recovered plaintext or hash digest) and its 128-bit tag in one cycle. Streams them out as 64-bit words over a valid/ready handshake with a last-word marker. Decouples the wide parallel core outputs from a narrow bus or host interface, and counts completed frames.

## Interface

Parameters:

- DATA_W, 256, width of captured data result; multiple of WORD_W
- TAG_W, 128, width of captured tag; multiple of WORD_W
- WORD_W, 64, output word width

Ports:

- clk  input  1  single clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- load  input  1  one-cycle pulse from core: c_in/t_in/mode valid this cycle
- mode  input  2  00 encrypt, 01 decrypt, 10 hash, 11 treated as 01
- c_in  input  DATA_W  core data result (C output of core)
- t_in  input  TAG_W  core tag result (T output of core)
- load_ready  output  1  high when a load will be accepted (IDLE)
- busy  output  1  high while a frame is being streamed (SEND)
- m_data  output  WORD_W  current output word
- m_valid  output  1  m_data valid
- m_ready  input  1  downstream accepts word when m_valid && m_ready
- m_last  output  1  high with the final word of a frame
- m_is_tag  output  1  high when m_data is a tag word
- overrun  output  1  sticky: a load arrived while not load_ready
- frame_cnt  output  16  completed frames; wraps 0xFFFF -> 0

## Operation

- States: IDLE, SEND.
- Frame length:
  - encrypt: N = DATA_W/WORD_W + TAG_W/WORD_W, i.e. 6 words (default). Data words first, then tag words.
  - decrypt and hash: N = DATA_W/WORD_W, i.e. 4 words. Data only; tag discarded.
- Word order: ascending. Word k = c_in[k*64 +: 64] for k < 4; word 4 = t_in[63:0]; word 5 = t_in[127:64].

IDLE:

- load_ready=1, busy=0, m_valid=0.
- On load: register c_in, t_in, frame length. Set index to 0. Go to SEND.

SEND:

- m_valid=1, m_data = word[index].
- m_last = (index == N-1).
- m_is_tag = (index >= DATA_W/WORD_W).
- On handshake with index < N-1: increment index.
- On handshake with index == N-1: go to IDLE and increment frame_cnt (mod 2^16).

Handshake rules:

- While m_valid && !m_ready, m_data, m_last and m_is_tag are held stable.
- m_valid never drops without a handshake, except on rst.

Overrun:

- A load while in SEND is ignored: the captured data is unchanged and overrun is set.
- This includes a load in the same cycle as the final handshake.
- overrun is cleared only by rst.

Storage: captured registers are not modified during SEND.

## Timing

- Reset values:
  - state IDLE, load_ready=1, busy=0, m_valid=0, m_last=0, m_is_tag=0
  - m_data=0, overrun=0, frame_cnt=0, index=0
- Latency: load in cycle n gives m_valid=1 with word 0 in cycle n+1.
- Throughput: one word per cycle while m_ready is held high. An encrypt frame occupies cycles n+1..n+6.
- After the final handshake in cycle t:
  - m_valid=0 and load_ready=1 in t+1
  - frame_cnt updated in t+1
- Earliest next accepted load is t+1, so the minimum frame spacing is N+1 cycles.
- Backpressure: each cycle with m_ready=0 stretches the frame by one cycle; no word is lost or duplicated.
- rst mid-frame: all state returns to reset values the next cycle. Remaining words are dropped and frame_cnt is not incremented.
- rst and load in the same cycle: rst wins; the load is dropped.

## Test plan

- Encrypt, m_ready=1:
  - Stimulus: c_in = {64'h0102030405060737, 64'h0102030405060720, 64'h0102030405060735, 64'h0102030405060720}, t_in = 128'h57368fee085688e93909d6f8d5cb32af, mode=00, load pulse.
  - Required: 6 consecutive words 0x…0720, 0x…0735, 0x…0720, 0x…0737, 0x3909d6f8d5cb32af, 0x57368fee085688e9.
  - m_is_tag high on the last 2 words; m_last high only on the 6th; frame_cnt=1 afterwards.
- Decrypt and hash: mode=01, then mode=10, same c_in -> each frame is 4 words, m_last on the 4th, m_is_tag never set; frame_cnt advances by 2.
- Backpressure: encrypt frame with m_ready toggled 1,0,0,1,0,1… -> word sequence identical to the first test; outputs held stable in every stalled cycle; frame ends only after 6 handshakes.
- Overrun:
  - load during word 2 of a frame -> frame completes with the original data and overrun=1.
  - load coincident with the final handshake -> ignored, overrun=1.
  - rst clears overrun.
- Reset mid-frame: assert rst after the 3rd handshake -> next cycle m_valid=0, load_ready=1, frame_cnt unchanged; a following load streams a full fresh frame from word 0.
- Counter wrap: preload 65535 completed frames (or force frame_cnt=16'hFFFF), run one frame -> frame_cnt=0.
